// File: rtl/csr_counter_ctrl.sv
// RV32 machine performance counter controller: mcycle, minstret and mcountinhibit.
// Decodes CSR accesses, arbitrates CSR writes against hardware increments, and returns registered read data.
module csr_counter_ctrl #(
  parameter int COUNT_LEN = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_retired,
  input  logic                 csr_req,
  input  logic                 csr_we,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_rvalid,
  output logic                 csr_err,
  output logic [COUNT_LEN-1:0] cycle_out,
  output logic [COUNT_LEN-1:0] instret_out
);

  localparam int HALF = COUNT_LEN / 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_IR_LO,
    SEL_IR_HI,
    SEL_INH
  } sel_e;

  logic [COUNT_LEN-1:0] mcycle, minstret;
  logic [COUNT_LEN-1:0] cycle_nxt, instret_nxt;
  logic                 inh_cy, inh_ir;
  sel_e                 sel;
  logic                 mapped, ro, acc_err, wr_en;
  logic [XLEN-1:0]      rd_val;

  // The user-level aliases at 0xC.. share storage with the machine counters but are read-only.
  always_comb begin
    sel    = SEL_NONE;
    mapped = 1'b1;
    ro     = 1'b0;
    case (csr_addr)
      12'hB00: sel = SEL_CYC_LO;
      12'hB80: sel = SEL_CYC_HI;
      12'hB02: sel = SEL_IR_LO;
      12'hB82: sel = SEL_IR_HI;
      12'hC00: begin sel = SEL_CYC_LO; ro = 1'b1; end
      12'hC80: begin sel = SEL_CYC_HI; ro = 1'b1; end
      12'hC02: begin sel = SEL_IR_LO;  ro = 1'b1; end
      12'hC82: begin sel = SEL_IR_HI;  ro = 1'b1; end
      12'h320: sel = SEL_INH;
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_CYC_LO: rd_val = mcycle[HALF-1:0];
      SEL_CYC_HI: rd_val = mcycle[COUNT_LEN-1:HALF];
      SEL_IR_LO:  rd_val = minstret[HALF-1:0];
      SEL_IR_HI:  rd_val = minstret[COUNT_LEN-1:HALF];
      SEL_INH: begin
        rd_val[0] = inh_cy;
        rd_val[2] = inh_ir;
      end
      default:    rd_val = '0;
    endcase
  end

  assign acc_err = csr_req & (~mapped | (csr_we & ro));
  assign wr_en   = csr_req & csr_we & mapped & ~ro;

  // A CSR write replaces the increment of the counter it targets; the increment is lost on purpose.
  always_comb begin
    cycle_nxt   = inh_cy ? mcycle : mcycle + {{(COUNT_LEN-1){1'b0}}, 1'b1};
    instret_nxt = (instr_retired & ~inh_ir) ? minstret + {{(COUNT_LEN-1){1'b0}}, 1'b1} : minstret;
    if (wr_en) begin
      case (sel)
        SEL_CYC_LO: cycle_nxt   = {mcycle[COUNT_LEN-1:HALF], csr_wdata};
        SEL_CYC_HI: cycle_nxt   = {csr_wdata, mcycle[HALF-1:0]};
        SEL_IR_LO:  instret_nxt = {minstret[COUNT_LEN-1:HALF], csr_wdata};
        SEL_IR_HI:  instret_nxt = {csr_wdata, minstret[HALF-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle     <= '0;
      minstret   <= '0;
      inh_cy     <= 1'b0;
      inh_ir     <= 1'b0;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      csr_err    <= 1'b0;
    end else begin
      mcycle     <= cycle_nxt;
      minstret   <= instret_nxt;
      csr_rvalid <= csr_req;
      csr_err    <= acc_err;
      if (csr_req) begin
        csr_rdata <= acc_err ? '0 : rd_val;
      end
      if (wr_en && sel == SEL_INH) begin
        inh_cy <= csr_wdata[0];
        inh_ir <= csr_wdata[2];
      end
    end
  end

  assign cycle_out   = mcycle;
  assign instret_out = minstret;

endmodule
